// File: rtl/fft_out_serializer.sv
// fft_out_serializer: captures a 16-point FFT frame in bit-reversed order and streams it out in natural
// order, one complex sample per valid/ready beat. Define FFT_SER_PINGPONG_EN to add a shadow buffer so
// that consecutive frames stream back to back with no gap.
module fft_out_serializer #(
    parameter int DATA_WIDTH = 20
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_WIDTH*16-1:0] x_in_flat_real,
    input  logic [DATA_WIDTH*16-1:0] x_in_flat_imag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    out_real,
    output logic [DATA_WIDTH-1:0]    out_imag,
    output logic [3:0]               out_index,
    output logic                     out_last,
    output logic                     busy
);
    typedef enum logic {IDLE, STREAM} state_t;
    state_t state, state_nx;
    logic [DATA_WIDTH-1:0] in_re [16];
    logic [DATA_WIDTH-1:0] in_im [16];
    logic [DATA_WIDTH-1:0] buf_re [16];
    logic [DATA_WIDTH-1:0] buf_im [16];
    logic       cap, beat, fin, load_in, adv, stop;
    logic [3:0] k_nx;

    function automatic logic [3:0] bitrev4(input logic [3:0] v);
        return {v[0], v[1], v[2], v[3]};
    endfunction

    // split the flattened buses; element 0 sits in the most significant slot
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            in_re[i] = x_in_flat_real[DATA_WIDTH*(16-i)-1 -: DATA_WIDTH];
            in_im[i] = x_in_flat_imag[DATA_WIDTH*(16-i)-1 -: DATA_WIDTH];
        end
    end

    assign k_nx     = out_index + 4'd1;
    assign cap      = in_valid && in_ready;
    assign beat     = out_valid && out_ready;
    assign fin      = beat && (out_index == 4'd15);
    assign out_last = out_valid && (out_index == 4'd15);

`ifdef FFT_SER_PINGPONG_EN
    logic [DATA_WIDTH-1:0] sh_re [16];
    logic [DATA_WIDTH-1:0] sh_im [16];
    logic sh_full, fill_sh, load_sh;

    assign in_ready = !rst && ((state == IDLE) || !sh_full);
    assign busy     = (state == STREAM) || sh_full;
    // a capture that is not going straight into the active buffer parks in the shadow
    assign fill_sh  = cap && !load_in;

    // shadow buffer: filled while streaming, released when its frame is swapped in
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_full <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                sh_re[i] <= '0;
                sh_im[i] <= '0;
            end
        end else if (fill_sh) begin
            sh_full <= 1'b1;
            sh_re   <= in_re;
            sh_im   <= in_im;
        end else if (load_sh) begin
            sh_full <= 1'b0;
        end
    end
`else
    assign in_ready = !rst && (state == IDLE);
    assign busy     = state == STREAM;
`endif

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // next state and datapath controls; the k=15 handshake always closes the frame
    always_comb begin
        state_nx = state;
        load_in  = 1'b0;
        adv      = 1'b0;
        stop     = 1'b0;
`ifdef FFT_SER_PINGPONG_EN
        load_sh  = 1'b0;
`endif
        if (state == IDLE) begin
            if (cap) begin
                state_nx = STREAM;
                load_in  = 1'b1;
            end
        end else if (fin) begin
`ifdef FFT_SER_PINGPONG_EN
            if (sh_full) load_sh = 1'b1;
            else if (cap) load_in = 1'b1;
            else begin
                state_nx = IDLE;
                stop     = 1'b1;
            end
`else
            state_nx = IDLE;
            stop     = 1'b1;
`endif
        end else if (beat) begin
            adv = 1'b1;
        end
    end

    // active frame buffer and registered output sample
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_real  <= '0;
            out_imag  <= '0;
            out_index <= '0;
            for (int i = 0; i < 16; i++) begin
                buf_re[i] <= '0;
                buf_im[i] <= '0;
            end
        end else if (load_in) begin
            buf_re    <= in_re;
            buf_im    <= in_im;
            out_valid <= 1'b1;
            out_index <= '0;
            out_real  <= in_re[0];
            out_imag  <= in_im[0];
`ifdef FFT_SER_PINGPONG_EN
        end else if (load_sh) begin
            buf_re    <= sh_re;
            buf_im    <= sh_im;
            out_valid <= 1'b1;
            out_index <= '0;
            out_real  <= sh_re[0];
            out_imag  <= sh_im[0];
`endif
        end else if (adv) begin
            out_index <= k_nx;
            out_real  <= buf_re[bitrev4(k_nx)];
            out_imag  <= buf_im[bitrev4(k_nx)];
        end else if (stop) begin
            out_valid <= 1'b0;
            out_index <= '0;
        end
    end
endmodule

// File: doc/fft_out_serializer.md
Name: fft_out_serializer

Overview:
- Final-stage reader for the 16-point FFT pipeline.
- Accepts one 16-element complex frame on the flattened parallel bus written by the last butterfly round.
- Reorders the frame from bit-reversed to natural frequency order.
- Streams the frame out one complex sample per beat over a valid/ready interface, with backpressure, to downstream consumers (magnitude, UART/DMA packers).

Parameters:
- DATA_WIDTH, 20, signed width of each real/imag component.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  frame on x_in_flat_* is valid
- in_ready  out  1  block can capture a frame this cycle
- x_in_flat_real  in  DATA_WIDTH*16  element i at bits [DATA_WIDTH*(16-i)-1 -: DATA_WIDTH], signed
- x_in_flat_imag  in  DATA_WIDTH*16  same packing as real
- out_valid  out  1  out_* hold a valid sample
- out_ready  in  1  downstream accepts sample
- out_real  out  DATA_WIDTH  signed real component
- out_imag  out  DATA_WIDTH  signed imag component
- out_index  out  4  natural-order frequency bin k of current sample
- out_last  out  1  high with bin 15
- busy  out  1  frame held or streaming

Behaviour:
- Reset (async assert, sync release): state IDLE, out_valid=0, out_real=0, out_imag=0, out_index=0, out_last=0, busy=0, frame buffer cleared. in_ready=0 while rst is high.
- Frame buffer: 16 x {real, imag} registers, DATA_WIDTH each. No arithmetic and no width change; samples pass bit-exact.
- Reorder: bin k is taken from buffer element bitrev4(k). Sequence 0->0, 1->8, 2->4, 3->12, 4->2, ..., 15->15.
- State IDLE:
  - in_ready=1, busy=0.
  - in_valid&&in_ready at edge N: capture both buses, go to STREAM.
  - At edge N+1 outputs are valid: out_valid=1, out_index=0, data=element 0.
- State STREAM:
  - in_ready=0, busy=1.
  - Outputs are registered and held stable while out_valid && !out_ready.
  - Each accepted beat (out_valid&&out_ready) advances k by 1 and loads the next sample on the same edge.
  - out_last=1 exactly when out_index=15.
  - Accepted beat with k=15: out_valid=0, out_last=0, out_index=0 next cycle, return to IDLE.
- Latency: first sample 1 cycle after capture. Full frame 16 beats at out_ready=1. Input throughput without the optional feature: one frame per 17 cycles minimum (one IDLE cycle between frames).
- in_valid while in STREAM is ignored; the frame is not captured, and upstream must hold it until in_ready.
- out_ready asserted with out_valid=0 has no effect.
- Reset mid-frame: frame discarded immediately, outputs return to reset values; no partial frame resumes after reset.
- Counter k is 4 bits and never wraps within a frame; the k=15 handshake always ends the frame.

Optional Feature:
- Macro FFT_SER_PINGPONG_EN.
- When defined:
  - A second (shadow) 16-entry buffer is added.
  - In STREAM, in_ready = shadow empty; a captured frame fills the shadow.
  - On the k=15 handshake with shadow full: swap buffers, stay in STREAM, next cycle shows the new frame's bin 0. Back-to-back frames have zero gap.
  - Shadow empties on swap.
  - Capture and swap in the same cycle is legal: the new frame lands in the freed shadow.
  - busy=1 when either buffer is full.
- When undefined: single buffer, behaviour exactly as above.

Test Plan:
- Reset then load element i real=1000*i, imag=-i, out_ready=1 -> 16 beats in consecutive cycles, real sequence 0,8000,4000,12000,2000,10000,6000,14000,1000,9000,5000,13000,3000,11000,7000,15000; imag = negated index; out_last only on beat 16; in_ready=0 throughout.
- Same frame, out_ready toggled 1,0,0,1 repeating -> each sample held stable while stalled; order unchanged; exactly 16 accepted beats.
- in_valid held high with a second frame (real=-524288 for all elements) during streaming -> not captured until IDLE; after 1 gap cycle, 16 beats of -524288 (full-scale negative passes unchanged).
- Assert rst at beat 5 of a frame -> out_valid=0 and outputs zero immediately; after release, in_ready=1 and the next frame starts at bin 0.
- FFT_SER_PINGPONG_EN: two frames presented back to back -> 32 consecutive beats with no gap; out_last on beats 16 and 32; in_ready drops while the shadow is full.
